// File: rtl/sram_req_ctrl.sv
// Request/response front end for a single-port SRAM with one-cycle registered read latency.
// Read data bypasses straight to the response port or lands in a 2-entry skid FIFO.
module sram_req_ctrl #(
  parameter int WIDTH    = 32,
  parameter int LG_DEPTH = 6,
  parameter int BYTESIZE = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_rw,
  input  logic [LG_DEPTH-1:0]         req_addr,
  input  logic [WIDTH/BYTESIZE-1:0]   req_bm,
  input  logic [WIDTH-1:0]            req_wdata,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic [WIDTH-1:0]            resp_rdata,
  output logic [LG_DEPTH-1:0]         sram_a,
  output logic [WIDTH/BYTESIZE-1:0]   sram_bm,
  output logic                        sram_web,
  output logic                        sram_csb,
  output logic                        sram_oeb,
  output logic [WIDTH-1:0]            sram_i,
  input  logic [WIDTH-1:0]            sram_o
);

  logic             r_pend;
  logic [1:0]       r_count;
  logic             r_head;
  logic             r_tail;
  logic [WIDTH-1:0] r_fifo [2];

  logic       w_accept;
  logic       w_push;
  logic       w_pop;
  logic [1:0] w_occ;

  // Handshakes, SRAM drive and response selection
  always_comb begin
    w_occ      = r_count + {1'b0, r_pend};
    // Occupancy counts the read in flight so a response always has a slot waiting.
    req_ready  = !reset && (w_occ < 2'd2);
    w_accept   = req_valid && req_ready;
    resp_valid = !reset && ((r_count != 2'd0) || r_pend);
    resp_rdata = (r_count != 2'd0) ? r_fifo[r_head] : sram_o;
    w_pop      = resp_ready && (r_count != 2'd0);
    w_push     = r_pend && !((r_count == 2'd0) && resp_ready);
    sram_csb   = !w_accept;
    sram_web   = !(w_accept && req_rw);
    sram_a     = req_addr;
    sram_bm    = req_bm;
    sram_i     = req_wdata;
    sram_oeb   = 1'b0;
  end

  // Pending-read flag, FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend  <= 1'b0;
      r_count <= 2'd0;
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
    end else begin
      r_pend <= w_accept && !req_rw;
      if (w_push) r_tail <= !r_tail;
      if (w_pop)  r_head <= !r_head;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage captures SRAM read data that was not consumed on arrival
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_tail] <= sram_o;
  end

  sram_req_ctrl_chk u_chk (
    .clk    (clk),
    .reset  (reset),
    .i_push (w_push),
    .i_count(r_count),
    .i_pend (r_pend)
  );

endmodule

// Occupancy checks for sram_req_ctrl.
module sram_req_ctrl_chk (
  input logic       clk,
  input logic       reset,
  input logic       i_push,
  input logic [1:0] i_count,
  input logic       i_pend
);

  a_no_push_when_full: assert property (@(posedge clk) disable iff (reset)
    !(i_push && (i_count == 2'd2)));

  a_occupancy_bound: assert property (@(posedge clk) disable iff (reset)
    (({1'b0, i_count} + {2'b00, i_pend}) <= 3'd2));

endmodule
